// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-master round-robin arbiter for the combinational instruction ROM port
// Registers the ROM word into a one-entry response buffer; a consumed response frees the slot that cycle.
module rom_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_valid,
  input  logic [ADDR_W-1:0] m0_req_addr,
  output logic              m0_req_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m0_rsp_ready,
  input  logic              m1_req_valid,
  input  logic [ADDR_W-1:0] m1_req_addr,
  output logic              m1_req_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  input  logic              m1_rsp_ready,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              grant_id
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] rsp_buf;

  logic owner_rsp_ready;
  logic free;
  logic grant;
  logic winner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_buf    <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        rsp_buf    <= rom_data;
        owner      <= winner;
        last_grant <= winner;
      end
    end
  end

  // rst gates the grant path so nothing is requested from the ROM while held in reset.
  always_comb begin
    owner_rsp_ready = owner ? m1_rsp_ready : m0_rsp_ready;
    free            = rst && ((state == IDLE) || owner_rsp_ready);
    grant           = free && (m0_req_valid || m1_req_valid);
    winner          = (m0_req_valid && m1_req_valid) ? ~last_grant : m1_req_valid;

    next_state = state;
    if (grant) begin
      next_state = RESP;
    end else if ((state == RESP) && owner_rsp_ready) begin
      next_state = IDLE;
    end

    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    rom_ce       = 1'b0;
    rom_addr     = '0;
    if (grant) begin
      rom_ce = 1'b1;
      if (winner) begin
        m1_req_ready = 1'b1;
        rom_addr     = m1_req_addr;
      end else begin
        m0_req_ready = 1'b1;
        rom_addr     = m0_req_addr;
      end
    end

    m0_rsp_valid = (state == RESP) && !owner;
    m1_rsp_valid = (state == RESP) && owner;
    m0_rsp_data  = rsp_buf;
    m1_rsp_data  = rsp_buf;
    grant_id     = owner;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed self-checking bench for rom_port_arbiter
// ROM model: 0x8000_0000 -> 0x0000_0413, otherwise low address word xor 0xA5A5_0000.
module tb_rom_port_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              m0_req_valid;
  logic [ADDR_W-1:0] m0_req_addr;
  logic              m0_req_ready;
  logic              m0_rsp_valid;
  logic [DATA_W-1:0] m0_rsp_data;
  logic              m0_rsp_ready;
  logic              m1_req_valid;
  logic [ADDR_W-1:0] m1_req_addr;
  logic              m1_req_ready;
  logic              m1_rsp_valid;
  logic [DATA_W-1:0] m1_rsp_data;
  logic              m1_rsp_ready;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              grant_id;

  int errors = 0;
  int checks = 0;

  rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_ready(m0_req_ready),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_ready(m0_rsp_ready),
    .m1_req_valid(m1_req_valid), .m1_req_addr(m1_req_addr), .m1_req_ready(m1_req_ready),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_ready(m1_rsp_ready),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (rom_addr == 64'h0000_0000_8000_0000) rom_data = 32'h0000_0413;
    else rom_data = rom_addr[31:0] ^ 32'hA5A5_0000;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_req_valid = 1'b1; m0_req_addr = 64'h8000_0000; m0_rsp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_req_addr = 64'h0;         m1_rsp_ready = 1'b0;
    #3;
    check("rst_m0_req_ready", m0_req_ready, 0);
    check("rst_m1_req_ready", m1_req_ready, 0);
    check("rst_m0_rsp_valid", m0_rsp_valid, 0);
    check("rst_m1_rsp_valid", m1_rsp_valid, 0);
    check("rst_rom_ce", rom_ce, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_rsp_data", m0_rsp_data, 0);
    step(); step();

    // Release reset: m0 granted immediately.
    rst = 1'b1; m0_rsp_ready = 1'b1; #1;
    check("rel_m0_req_ready", m0_req_ready, 1);
    check("rel_rom_ce", rom_ce, 1);
    check("rel_rom_addr", rom_addr, 64'h8000_0000);
    step(); m0_req_valid = 1'b0; #1;
    check("single_rsp_valid", m0_rsp_valid, 1);
    check("single_rsp_data", m0_rsp_data, 32'h0000_0413);
    check("single_grant_id", grant_id, 0);
    check("single_m1_rsp_valid", m1_rsp_valid, 0);
    check("single_rom_ce", rom_ce, 0);
    step(); #1;
    check("single_idle", m0_rsp_valid, 0);

    // Streaming three fetches back to back.
    m0_req_valid = 1'b1; m0_req_addr = 64'h8000_0000; #1;
    check("stream_rdy0", m0_req_ready, 1);
    step(); m0_req_addr = 64'h8000_0004; #1;
    check("stream_rdy1", m0_req_ready, 1);
    check("stream_rsp0", m0_rsp_data, 32'h0000_0413);
    check("stream_vld0", m0_rsp_valid, 1);
    step(); m0_req_addr = 64'h8000_0008; #1;
    check("stream_rdy2", m0_req_ready, 1);
    check("stream_rsp1", m0_rsp_data, 32'h25A5_0004);
    check("stream_vld1", m0_rsp_valid, 1);
    step(); m0_req_valid = 1'b0; #1;
    check("stream_rsp2", m0_rsp_data, 32'h25A5_0008);
    check("stream_vld2", m0_rsp_valid, 1);
    step(); #1;
    check("stream_idle", m0_rsp_valid, 0);

    // Tie round-robin right after a fresh reset.
    rst = 1'b0;
    step();
    rst = 1'b1; m1_rsp_ready = 1'b1;
    m0_req_valid = 1'b1; m0_req_addr = 64'h8000_0000;
    m1_req_valid = 1'b1; m1_req_addr = 64'h1000; #1;
    check("tie0_m0_ready", m0_req_ready, 1);
    check("tie0_m1_ready", m1_req_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      check("tie_m0_ready", m0_req_ready, (k % 2 == 0) ? 1 : 0);
      check("tie_m1_ready", m1_req_ready, (k % 2 == 1) ? 1 : 0);
      check("tie_grant_id", grant_id, (k % 2 == 1) ? 0 : 1);
      check("tie_rsp_data", m0_rsp_data, (k % 2 == 1) ? 32'h0000_0413 : 32'hA5A5_1000);
    end
    step(); m0_req_valid = 1'b0; m1_req_valid = 1'b0; #1;
    check("tie_last_m0_valid", m0_rsp_valid, 1);
    check("tie_last_data", m0_rsp_data, 32'h0000_0413);
    step(); #1;
    check("tie_idle", m0_rsp_valid | m1_rsp_valid, 0);

    // Backpressure on an m1 response while m0 waits.
    m1_rsp_ready = 1'b0; m1_req_valid = 1'b1; m1_req_addr = 64'h2000; #1;
    check("bp_m1_ready", m1_req_ready, 1);
    step(); m1_req_valid = 1'b0; m0_req_valid = 1'b1; m0_req_addr = 64'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_m1_rsp_valid", m1_rsp_valid, 1);
      check("bp_rsp_data", m1_rsp_data, 32'hA5A5_2000);
      check("bp_m0_ready", m0_req_ready, 0);
      check("bp_rom_ce", rom_ce, 0);
      step();
    end
    m1_rsp_ready = 1'b1; #1;
    check("bp_rel_m0_ready", m0_req_ready, 1);
    check("bp_rel_rom_ce", rom_ce, 1);
    check("bp_rel_rom_addr", rom_addr, 64'h8000_0000);
    step(); m0_req_valid = 1'b0; m0_rsp_ready = 1'b0; #1;
    check("bp_m0_rsp_valid", m0_rsp_valid, 1);
    check("bp_m0_rsp_data", m0_rsp_data, 32'h0000_0413);
    check("bp_m1_rsp_clear", m1_rsp_valid, 0);

    // Mid-operation asynchronous reset.
    step(); #1;
    check("mid_held", m0_rsp_valid, 1);
    rst = 1'b0; #1;
    check("mid_rst_m0_vld", m0_rsp_valid, 0);
    check("mid_rst_m1_vld", m1_rsp_valid, 0);
    check("mid_rst_data", m0_rsp_data, 0);
    step();
    rst = 1'b1;
    m0_req_valid = 1'b1; m0_req_addr = 64'h8000_0000;
    m1_req_valid = 1'b1; m1_req_addr = 64'h1000; #1;
    check("mid_no_rsp", m0_rsp_valid | m1_rsp_valid, 0);
    check("mid_tie_m0", m0_req_ready, 1);
    check("mid_tie_m1", m1_req_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction ROM port (ce/addr -> inst) between two requesters.
- m0 is the core fetch unit; m1 is the debug/loader read port.
- Accepts requests over valid/ready, forwards the winning address to the ROM, and registers the returned word into a one-entry response buffer.
- Sits between the core/debug masters and the instruction ROM inside the top-level.

Parameters:
- ADDR_W, 64, width of the instruction address bus
- DATA_W, 32, width of the instruction word

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m0_req_valid  in  1  fetch request valid
- m0_req_addr  in  ADDR_W  fetch address
- m0_req_ready  out  1  fetch request accepted this cycle
- m0_rsp_valid  out  1  fetch response valid
- m0_rsp_data  out  DATA_W  fetched instruction word
- m0_rsp_ready  in  1  fetch unit consumes response
- m1_req_valid, m1_req_addr, m1_req_ready, m1_rsp_valid, m1_rsp_data, m1_rsp_ready: same as m0, for the debug port
- rom_ce  out  1  ROM chip enable
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM read data, combinational from rom_addr
- grant_id  out  1  owner of the buffered response (0 = m0, 1 = m1)

Behaviour:
- Registers:
  - state: IDLE or RESP
  - owner (1 bit)
  - last_grant (1 bit)
  - rsp_buf (DATA_W)
- Reset values (asynchronous on rst = 0):
  - state = IDLE, owner = 0, last_grant = 1 (so m0 wins the first tie), rsp_buf = 0
  - All outputs 0: req_ready, rsp_valid, rsp_data, rom_ce, rom_addr, grant_id
- Slot free (comb):
  - free = (state == IDLE) OR (state == RESP AND rsp_ready of owner == 1)
  - A response being consumed frees the slot in the same cycle, giving back-to-back throughput of 1 word/cycle.
- Arbitration (comb, evaluated only when free):
  - Only one valid: it wins.
  - Both valid: round-robin; the winner is NOT last_grant.
  - Neither valid: no grant.
- Grant cycle (comb):
  - winner's req_ready = 1; loser's req_ready = 0
  - rom_ce = 1; rom_addr = winner's req_addr
- When no grant: rom_ce = 0, rom_addr = 0, both req_ready = 0.
- On the grant edge:
  - rsp_buf <= rom_data
  - owner <= winner
  - last_grant <= winner
  - state <= RESP
- Latency: response valid exactly 1 cycle after the accept cycle.
- RESP state outputs:
  - owner's rsp_valid = 1; the other rsp_valid = 0
  - both rsp_data = rsp_buf; grant_id = owner
- Response consumed with no new grant: state <= IDLE.
- Response not consumed (owner rsp_ready = 0):
  - hold rsp_buf, owner and state unchanged
  - both req_ready = 0
  - rom_ce = 0
- Requester rules:
  - Must hold valid and addr stable until ready.
  - The arbiter never drops an accepted request.
- The non-owner's rsp_ready is ignored.
- Address passed to the ROM unmodified; no alignment checking.
- Reset mid-operation: a pending response is discarded; no rsp_valid after reset is released until a new grant.

Test Plan:
- Reset: hold rst = 0 with m0_req_valid = 1 -> all outputs 0; release rst -> m0_req_ready = 1, rom_ce = 1, rom_addr = m0 addr that cycle.
- Single fetch: m0 addr 0x8000_0000, ROM returns 0x0000_0413 -> next cycle m0_rsp_valid = 1, m0_rsp_data = 0x0000_0413, grant_id = 0; rsp_ready = 1 -> IDLE.
- Streaming: m0 requests 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles with rsp_ready held 1 -> three grants on consecutive cycles, responses on 3 consecutive cycles in order, no bubbles.
- Tie round-robin: both valid continuously after reset -> grants alternate m0, m1, m0, m1; grant_id matches each response.
- Backpressure: m1 response pending with m1_rsp_ready = 0 for 4 cycles while m0 requests -> rsp_buf and m1_rsp_valid held, m0_req_ready = 0, rom_ce = 0; on m1_rsp_ready = 1 -> m0 granted that same cycle.
- Mid-operation reset: pull rst low while in RESP -> m*_rsp_valid drops to 0 immediately (asynchronously); after release, last_grant = 1, so m0 wins a tie.
